// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: writes the captured pixel stream into frame-buffer RAM as a linear raster
// Ports: PCLK clock, rst sync active-low reset; start/continuous arm control;
// VSYNC/px_data/px_valid/line_end from capture; mem_addr/mem_data/mem_we RAM write port;
// busy/frame_done/err_overflow status, all registered.
module frame_buffer_writer #(
  parameter int H_PIX = 160,
  parameter int V_LINES = 120,
  parameter int AW = 15
) (
  input  logic          PCLK,
  input  logic          rst,
  input  logic          start,
  input  logic          continuous,
  input  logic          VSYNC,
  input  logic [7:0]    px_data,
  input  logic          px_valid,
  input  logic          line_end,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_we,
  output logic          busy,
  output logic          frame_done,
  output logic          err_overflow
);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;
  state_t state, next_state;
  logic vs_prev, vs_fall, vs_rise, cap, accept, drop, last_line;
  logic [9:0] col, row;
  logic [AW-1:0] line_base, addr_d;
  logic [7:0] data_d;
  logic we_d, busy_d, done_d, err_d;
  assign vs_fall = vs_prev & ~VSYNC;
  assign vs_rise = ~vs_prev & VSYNC;
  assign cap = state == CAPTURE;
  assign accept = cap && px_valid && col < 10'(H_PIX) && row < 10'(V_LINES);
  // col saturates at H_PIX, so any further pixel on this line is an overflow
  assign drop = cap && px_valid && col >= 10'(H_PIX);
  assign last_line = line_end && row == 10'(V_LINES - 1);
  always_ff @(posedge PCLK)
    state <= !rst ? IDLE : next_state;
  always_comb begin
    next_state = state == IDLE       ? (start ? WAIT_FRAME : IDLE) :
                 state == WAIT_FRAME ? (vs_fall ? CAPTURE : WAIT_FRAME) :
                 state == CAPTURE    ? ((vs_rise || last_line) ? DONE : CAPTURE) :
                                       (continuous ? WAIT_FRAME : IDLE);
  end
  always_comb begin
    we_d = accept;
    addr_d = accept ? line_base + AW'(col) : mem_addr;
    data_d = accept ? px_data : mem_data;
    busy_d = next_state != IDLE;
    done_d = next_state == DONE;
    err_d = (state == IDLE && start) ? 1'b0 : err_overflow | drop;
  end
  // counters are held at zero outside CAPTURE so every frame starts at address 0
  always_ff @(posedge PCLK) begin
    if (!rst) begin
      mem_addr <= '0;
      mem_data <= '0;
      mem_we <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      err_overflow <= 1'b0;
      col <= '0;
      row <= '0;
      line_base <= '0;
      vs_prev <= 1'b0;
    end else begin
      mem_addr <= addr_d;
      mem_data <= data_d;
      mem_we <= we_d;
      busy <= busy_d;
      frame_done <= done_d;
      err_overflow <= err_d;
      vs_prev <= VSYNC;
      col <= (!cap || line_end) ? '0 : accept ? col + 10'd1 : col;
      row <= !cap ? '0 : line_end ? row + 10'd1 : row;
      line_base <= !cap ? '0 : line_end ? line_base + AW'(H_PIX) : line_base;
    end
  end
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: directed self-checking bench for frame_buffer_writer (H_PIX=4, V_LINES=3)
module tb_frame_buffer_writer;
  logic PCLK = 0, rst = 0, start = 0, continuous = 0, VSYNC = 0, px_valid = 0, line_end = 0;
  logic [7:0] px_data = 0;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic mem_we, busy, frame_done, err_overflow;
  int total = 0, bad = 0, nwr = 0, ndone = 0;
  bit touched [16];
  frame_buffer_writer #(.H_PIX(4), .V_LINES(3), .AW(4)) dut (
    .PCLK(PCLK), .rst(rst), .start(start), .continuous(continuous), .VSYNC(VSYNC),
    .px_data(px_data), .px_valid(px_valid), .line_end(line_end), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .busy(busy), .frame_done(frame_done),
    .err_overflow(err_overflow)
  );
  always #5 PCLK = ~PCLK;
  always @(negedge PCLK) begin
    if (mem_we) begin
      nwr++;
      touched[mem_addr] = 1;
    end
    if (frame_done) ndone++;
  end
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask
  task automatic clear_log();
    nwr = 0;
    ndone = 0;
    for (int i = 0; i < 16; i++) touched[i] = 0;
  endtask
  task automatic arm();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic frame_begin();
    VSYNC = 1;
    tick();
    VSYNC = 0;
    tick();
  endtask
  task automatic pix(input logic [7:0] d);
    px_valid = 1;
    px_data = d;
    tick();
    px_valid = 0;
  endtask
  task automatic eol();
    line_end = 1;
    tick();
    line_end = 0;
  endtask

  task automatic test_reset();
    rst = 0; start = 1; px_valid = 1;
    tick(); tick();
    total++; if ({mem_we, busy, frame_done, err_overflow} !== 4'b0) begin bad++; $display("FAIL reset_flags got %b want 0000", {mem_we, busy, frame_done, err_overflow}); end
    total++; if ({mem_addr, mem_data} !== 12'h0) begin bad++; $display("FAIL reset_bus got %h want 000", {mem_addr, mem_data}); end
    start = 0; px_valid = 0; rst = 1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    clear_log();
    arm();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL nom_busy got %b want 1", busy); end
    frame_begin();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        pix(8'(8'h10 + r * 4 + c));
        total++; if (mem_we !== 1'b1 || mem_addr !== 4'(r * 4 + c) || mem_data !== 8'(8'h10 + r * 4 + c)) begin
          bad++; $display("FAIL nom_write we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", mem_we, mem_addr, mem_data, r * 4 + c, 8'h10 + r * 4 + c);
        end
      end
      eol();
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL nom_eol_we got %b want 0", mem_we); end
    end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL nom_done got %b want 1", frame_done); end
    tick();
    total++; if (frame_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL nom_idle done=%b busy=%b want 0 0", frame_done, busy); end
    total++; if (nwr !== 12 || ndone !== 1) begin bad++; $display("FAIL nom_counts writes=%0d dones=%0d want 12 1", nwr, ndone); end
  endtask

  task automatic test_long_line();
    clear_log();
    arm();
    frame_begin();
    for (int c = 0; c < 6; c++) begin
      pix(8'(8'h20 + c));
      total++; if (mem_we !== (c < 4) || (c < 4 && mem_addr !== 4'(c))) begin
        bad++; $display("FAIL long_px%0d we=%b addr=%0d want we=%b addr=%0d", c, mem_we, mem_addr, c < 4, c);
      end
    end
    total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL long_err got %b want 1", err_overflow); end
    eol();
    pix(8'h30);
    total++; if (mem_we !== 1'b1 || mem_addr !== 4'd4 || mem_data !== 8'h30) begin bad++; $display("FAIL long_line1 we=%b addr=%0d data=%h want 1 4 30", mem_we, mem_addr, mem_data); end
    VSYNC = 1;
    tick();
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL long_done got %b want 1", frame_done); end
    tick();
    total++; if (err_overflow !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL long_sticky err=%b busy=%b want 1 0", err_overflow, busy); end
  endtask

  task automatic test_short();
    clear_log();
    arm();
    total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL short_errclr got %b want 0", err_overflow); end
    frame_begin();
    pix(8'h40); pix(8'h41);
    eol();
    for (int c = 0; c < 4; c++) begin
      pix(8'(8'h50 + c));
      total++; if (mem_addr !== 4'(4 + c)) begin bad++; $display("FAIL short_addr got %0d want %0d", mem_addr, 4 + c); end
    end
    eol();
    VSYNC = 1;
    tick();
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL short_done got %b want 1", frame_done); end
    total++; if (touched[2] || touched[3] || !touched[0] || !touched[1] || nwr !== 6) begin
      bad++; $display("FAIL short_map t0..3=%b%b%b%b writes=%0d want 1100 6", touched[0], touched[1], touched[2], touched[3], nwr);
    end
    tick();
    total++; if (busy !== 1'b0 || err_overflow !== 1'b0) begin bad++; $display("FAIL short_idle busy=%b err=%b want 0 0", busy, err_overflow); end
  endtask

  task automatic test_sync_filter();
    clear_log();
    VSYNC = 0;
    tick();
    arm();
    px_valid = 1; px_data = 8'h77; line_end = 1;
    tick(); tick();
    VSYNC = 1;
    tick(); tick();
    px_valid = 0; line_end = 0;
    total++; if (nwr !== 0 || busy !== 1'b1 || ndone !== 0) begin bad++; $display("FAIL wait_filter writes=%0d busy=%b dones=%0d want 0 1 0", nwr, busy, ndone); end
    VSYNC = 0;
    tick();
    start = 1;
    pix(8'h60);
    total++; if (mem_we !== 1'b1 || mem_addr !== 4'd0) begin bad++; $display("FAIL cap_px0 we=%b addr=%0d want 1 0", mem_we, mem_addr); end
    pix(8'h61);
    start = 0;
    total++; if (mem_we !== 1'b1 || mem_addr !== 4'd1 || mem_data !== 8'h61) begin bad++; $display("FAIL cap_start_ign we=%b addr=%0d data=%h want 1 1 61", mem_we, mem_addr, mem_data); end
    VSYNC = 1;
    tick();
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL filt_done got %b want 1", frame_done); end
    tick();
  endtask

  task automatic test_continuous();
    clear_log();
    continuous = 1;
    arm();
    frame_begin();
    pix(8'h70); pix(8'h71);
    VSYNC = 1;
    tick();
    tick();
    total++; if (busy !== 1'b1 || ndone !== 1) begin bad++; $display("FAIL cont_rearm busy=%b dones=%0d want 1 1", busy, ndone); end
    VSYNC = 0;
    tick();
    pix(8'h72);
    total++; if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_data !== 8'h72) begin bad++; $display("FAIL cont_addr0 we=%b addr=%0d data=%h want 1 0 72", mem_we, mem_addr, mem_data); end
    continuous = 0;
    VSYNC = 1;
    tick();
    tick();
    total++; if (ndone !== 2 || busy !== 1'b0) begin bad++; $display("FAIL cont_dones dones=%0d busy=%b want 2 0", ndone, busy); end
  endtask

  task automatic test_reset_mid();
    arm();
    frame_begin();
    for (int c = 0; c < 4; c++) pix(8'(8'h80 + c));
    eol();
    pix(8'h84);
    total++; if (mem_we !== 1'b1 || mem_addr !== 4'd4) begin bad++; $display("FAIL mid_px4 we=%b addr=%0d want 1 4", mem_we, mem_addr); end
    rst = 0; px_valid = 1;
    tick();
    total++; if (mem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst we=%b busy=%b want 0 0", mem_we, busy); end
    rst = 1; px_valid = 0;
    tick();
    clear_log();
    frame_begin();
    pix(8'h90); pix(8'h91); pix(8'h92);
    total++; if (nwr !== 0 || busy !== 1'b0) begin bad++; $display("FAIL mid_nostart writes=%0d busy=%b want 0 0", nwr, busy); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_long_line();
    test_short();
    test_sync_filter();
    test_continuous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
